ring_pattern_gen: RTL
=====================

// Module: ring_pattern_gen
// PURPOSE
//  Parametrised concentric-ring VGA pixel generator; successor of the fixed rings effect.
//  Sits between hvsync_generator and the RGB222 output pins. Adds a bouncing ring centre,
//  multi-level speed, selectable colour modes and a registered pixel pipeline.
//  Emits rgb plus hsync/vsync delayed to match the pipeline.
// PARAMETERS
//  COORD_W     10   width of hpos/vpos and centre coordinates
//  ACC_W       8    ring phase/anim width (>=4); colour taken from its top 4 bits
//  SPEED_W     2    width of speed input; phase step = speed+1
//  H_ACTIVE    640  visible width; centre x range 0..H_ACTIVE-1
//  V_ACTIVE    480  visible height; centre y range 0..V_ACTIVE-1
//  CX_RESET    320  centre x after reset
//  CY_RESET    240  centre y after reset
//  BOUNCE_STEP 1    centre move per frame per axis when bouncing
// PORTS
//  clk         in   1        pixel clock
//  reset       in   1        asynchronous, active-high reset
//  hpos        in   COORD_W  current pixel x from sync generator
//  vpos        in   COORD_W  current pixel y from sync generator
//  display_on  in   1        visible-area flag
//  hsync_in    in   1        hsync from sync generator
//  vsync_in    in   1        vsync from sync generator
//  speed       in   SPEED_W  phase step minus one
//  direction   in   1        0 = rings move outward (phase -= step), 1 = inward (phase += step)
//  bounce_en   in   1        1 = centre bounces, 0 = centre holds
//  mode        in   2        colour mode (below)
//  rgb         out  6        {R1,R0,G1,G0,B1,B0}
//  hsync_out   out  1        hsync_in delayed 2 cycles
//  vsync_out   out  1        vsync_in delayed 2 cycles
// BEHAVIOUR
//  - Reset (async, active-high): phase=0, cx=CX_RESET, cy=CY_RESET, x/y move dirs = +,
//    mode_q=0, all pipeline regs 0 => rgb=0, hsync_out=0, vsync_out=0. Reset beats a tick.
//  - tick = (hpos==0 && vpos==0); fires once per frame. Only on tick:
//    phase <= phase -/+ (speed+1) mod 2^ACC_W; mode_q <= mode.
//    If bounce_en: move each axis by BOUNCE_STEP in its direction.
//  - Bounce, per axis: dir + and c+STEP > MAX => c<=MAX, dir<=-; dir - and c < STEP =>
//    c<=0, dir<=+; otherwise c<=c+/-STEP. MAX = H_ACTIVE-1 or V_ACTIVE-1.
//    bounce_en=0: centre and dirs hold. Mode changes mid-frame take effect after next tick.
//  - Pipeline, latency 2 cycles, 1 pixel/clk, no stalls:
//    S1: dx=|hpos-cx|, dy=|vpos-cy| (COORD_W bits, signed diff COORD_W+1);
//        register display_on, hsync_in, vsync_in.
//    S2: radius = max(dx,dy) + (min(dx,dy)>>1), COORD_W+1 bits, no overflow.
//        anim = radius[ACC_W-1:0] + phase, mod 2^ACC_W.
//        Register colour, display_on and syncs into the outputs.
//  - Let a3..a0 = anim[ACC_W-1..ACC_W-4]. Colour per mode_q:
//    0 rings:  R={a1,a0}, G={a2,a1}, B={a3,a2}
//    1 mono:   R=G=B={a3,a2}
//    2 bands:  rgb = {6{a3}}
//    3 invert: bitwise ~ of mode-0 colour
//  - rgb = 0 whenever delayed display_on = 0. Syncs pass through untouched (polarity kept).
//  - Uses the cx/cy/phase/mode_q value present when each pixel enters S1. A tick updates
//    these on pixel (0,0) itself, so pixel (0,0) uses the pre-tick values.
// TESTING
//  1 Reset asserted mid-frame => rgb/hsync_out/vsync_out=0 at once. After release,
//    centre=(320,240), phase=0.
//  2 phase=0, mode 0, display_on=1: pixel (320,240) => rgb=000000 two clocks later.
//    Pixel (336,240) (anim=0x10) => rgb=010000. Same pixel with display_on=0 => 000000.
//  3 speed=3, direction=1: three ticks => phase=12. Then direction=0, one tick => phase=8.
//    phase=0, speed=0, direction=0, one tick => phase=255 (wrap).
//  4 Switch mode 0->3 mid-frame => colour unchanged until after the next tick.
//    Then pixel (336,240) => rgb=101111.
//  5 BOUNCE_STEP=4, cx=636 moving +, bounce_en=1:
//    tick => cx=639 dir -; tick => cx=635. cy=2 moving - => 0, then 4.
//    bounce_en=0 => centre frozen.
//  6 Random hsync_in/vsync_in stream => hsync_out/vsync_out equal inputs delayed exactly
//    2 clocks. Reset held on the tick pixel => phase stays 0.

Source files
------------

// File: rtl/ring_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : ring_pattern_gen
// Brief    : Concentric-ring VGA pixel generator with a bouncing centre,
//            multi-level animation speed and selectable colour modes.
//            Two-stage pixel pipeline; hsync/vsync delayed to match.
// Revision : 1.0  initial release
// ============================================================================
module ring_pattern_gen #(
    parameter int COORD_W     = 10,
    parameter int ACC_W       = 8,
    parameter int SPEED_W     = 2,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int CX_RESET    = 320,
    parameter int CY_RESET    = 240,
    parameter int BOUNCE_STEP = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] hpos,
    input  logic [COORD_W-1:0] vpos,
    input  logic               display_on,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [SPEED_W-1:0] speed,
    input  logic               direction,
    input  logic               bounce_en,
    input  logic [1:0]         mode,
    output logic [5:0]         rgb,
    output logic               hsync_out,
    output logic               vsync_out
);

    // Per-axis travel direction of the ring centre.
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    localparam logic [COORD_W-1:0] c_x_max    = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] c_y_max    = COORD_W'(V_ACTIVE - 1);
    localparam logic [COORD_W-1:0] c_step     = COORD_W'(BOUNCE_STEP);
    localparam logic [COORD_W-1:0] c_cx_reset = COORD_W'(CX_RESET);
    localparam logic [COORD_W-1:0] c_cy_reset = COORD_W'(CY_RESET);

    // ------------------------------------------------------------------
    // Frame-rate state: ring phase, latched colour mode, centre, dirs
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]   r_phase;
    logic [1:0]         r_mode_q;
    logic [COORD_W-1:0] r_cx;
    logic [COORD_W-1:0] r_cy;
    dir_t               r_dir_x;
    dir_t               r_dir_y;

    logic               w_tick;
    logic [ACC_W-1:0]   w_phase_step;
    logic [COORD_W:0]   w_x_next;
    logic [COORD_W:0]   w_y_next;

    // Next position of one axis; result packed as {reverse_to_neg, coord}.
    // Clamps to the edge and turns around instead of wrapping.
    function automatic logic [COORD_W:0] bounce_next(
        input logic [COORD_W-1:0] c,
        input dir_t               dir,
        input logic [COORD_W-1:0] c_max
    );
        logic [COORD_W:0] sum;
        sum = {1'b0, c} + {1'b0, c_step};
        if (dir == DIR_POS) begin
            if (sum > {1'b0, c_max}) begin
                return {1'b1, c_max};
            end
            return {1'b0, sum[COORD_W-1:0]};
        end
        if (c < c_step) begin
            return {1'b0, {COORD_W{1'b0}}};
        end
        return {1'b1, c - c_step};
    endfunction

    assign w_tick       = (hpos == '0) && (vpos == '0);
    assign w_phase_step = ACC_W'(speed) + ACC_W'(1);
    assign w_x_next     = bounce_next(r_cx, r_dir_x, c_x_max);
    assign w_y_next     = bounce_next(r_cy, r_dir_y, c_y_max);

    // Once-per-frame update of phase, mode and (optionally) the centre.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase  <= '0;
            r_mode_q <= 2'd0;
            r_cx     <= c_cx_reset;
            r_cy     <= c_cy_reset;
            r_dir_x  <= DIR_POS;
            r_dir_y  <= DIR_POS;
        end else if (w_tick) begin
            r_phase  <= direction ? (r_phase + w_phase_step)
                                  : (r_phase - w_phase_step);
            r_mode_q <= mode;
            if (bounce_en) begin
                r_cx    <= w_x_next[COORD_W-1:0];
                r_dir_x <= w_x_next[COORD_W] ? DIR_NEG : DIR_POS;
                r_cy    <= w_y_next[COORD_W-1:0];
                r_dir_y <= w_y_next[COORD_W] ? DIR_NEG : DIR_POS;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: absolute distance from the centre on each axis
    // ------------------------------------------------------------------
    logic [COORD_W:0]   w_diff_x;
    logic [COORD_W:0]   w_diff_y;
    logic [COORD_W-1:0] w_abs_x;
    logic [COORD_W-1:0] w_abs_y;

    assign w_diff_x = {1'b0, hpos} - {1'b0, r_cx};
    assign w_diff_y = {1'b0, vpos} - {1'b0, r_cy};
    assign w_abs_x  = w_diff_x[COORD_W] ? COORD_W'(-w_diff_x) : COORD_W'(w_diff_x);
    assign w_abs_y  = w_diff_y[COORD_W] ? COORD_W'(-w_diff_y) : COORD_W'(w_diff_y);

    logic [COORD_W-1:0] r_dx;
    logic [COORD_W-1:0] r_dy;
    logic [ACC_W-1:0]   r_s1_phase;
    logic [1:0]         r_s1_mode;
    logic               r_s1_disp;
    logic               r_s1_hs;
    logic               r_s1_vs;

    // Stage-1 register; phase and mode travel with the pixel so a tick on
    // pixel (0,0) does not alter that pixel's own colour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dx       <= '0;
            r_dy       <= '0;
            r_s1_phase <= '0;
            r_s1_mode  <= 2'd0;
            r_s1_disp  <= 1'b0;
            r_s1_hs    <= 1'b0;
            r_s1_vs    <= 1'b0;
        end else begin
            r_dx       <= w_abs_x;
            r_dy       <= w_abs_y;
            r_s1_phase <= r_phase;
            r_s1_mode  <= r_mode_q;
            r_s1_disp  <= display_on;
            r_s1_hs    <= hsync_in;
            r_s1_vs    <= vsync_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: octagonal radius approximation, animation and colour
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] w_max;
    logic [COORD_W-1:0] w_min;
    logic [COORD_W:0]   w_radius;
    logic [ACC_W-1:0]   w_anim;
    logic [3:0]         w_nib;
    logic [5:0]         w_rings;
    logic [5:0]         w_colour;

    assign w_max    = (r_dx > r_dy) ? r_dx : r_dy;
    assign w_min    = (r_dx > r_dy) ? r_dy : r_dx;
    assign w_radius = {1'b0, w_max} + (COORD_W+1)'(w_min >> 1);
    assign w_anim   = ACC_W'(w_radius) + r_s1_phase;
    assign w_nib    = 4'(w_anim >> (ACC_W - 4));
    assign w_rings  = {w_nib[1], w_nib[0], w_nib[2], w_nib[1], w_nib[3], w_nib[2]};

    // Colour-mode selection from the top nibble of the animation value.
    always_comb begin
        w_colour = w_rings;
        case (r_s1_mode)
            2'd0:    w_colour = w_rings;
            2'd1:    w_colour = {3{w_nib[3], w_nib[2]}};
            2'd2:    w_colour = {6{w_nib[3]}};
            2'd3:    w_colour = ~w_rings;
            default: w_colour = w_rings;
        endcase
    end

    // Output register: blank outside the visible area, syncs pass through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb       <= 6'd0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            rgb       <= r_s1_disp ? w_colour : 6'd0;
            hsync_out <= r_s1_hs;
            vsync_out <= r_s1_vs;
        end
    end

endmodule
`default_nettype wire
